systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder_pkg.sv | 24 ++
 rtl/systolic_feeder_if.sv | 46 ++++
 rtl/skew_lane.sv | 37 +++
 rtl/systolic_feeder.sv | 147 ++++++++++++++
 tb/tb_systolic_feeder.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic operand feeder: data width, FSM states, flush length.
// Optional build macro SYSTOLIC_FEEDER_PERF_CNT_EN is consumed by the interface and top.
`ifndef DWIDTH
`define DWIDTH 8
`endif

package systolic_feeder_pkg;

  localparam int unsigned DataWidth = `DWIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StFlush,
    StDone
  } state_e;

  // Cycles needed after the last read for the most-skewed lane to drain.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// Control, operand-buffer and array-edge signals of the systolic feeder.
// With SYSTOLIC_FEEDER_PERF_CNT_EN defined the bundle also carries cycle_count.
interface systolic_feeder_if
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DW     = DataWidth
);

  logic              start;
  logic [ADDR_W-1:0] k_len;
  logic              busy;
  logic              done;
  logic              pe_clear;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [N*DW-1:0]   rd_data_a;
  logic [N*DW-1:0]   rd_data_b;
  logic [N*DW-1:0]   a_out;
  logic [N*DW-1:0]   b_out;
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  logic [31:0]       cycle_count;

  modport master (
    output start, k_len, rd_data_a, rd_data_b,
    input  busy, done, pe_clear, rd_en, rd_addr, a_out, b_out, cycle_count
  );

  modport slave (
    input  start, k_len, rd_data_a, rd_data_b,
    output busy, done, pe_clear, rd_en, rd_addr, a_out, b_out, cycle_count
  );
`else
  modport master (
    output start, k_len, rd_data_a, rd_data_b,
    input  busy, done, pe_clear, rd_en, rd_addr, a_out, b_out
  );

  modport slave (
    input  start, k_len, rd_data_a, rd_data_b,
    output busy, done, pe_clear, rd_en, rd_addr, a_out, b_out
  );
`endif

endinterface

// File: rtl/skew_lane.sv
// Per-lane diagonal skew: Depth-stage data+valid delay line, output forced to zero when invalid.
// Depth 0 is a gated pass-through.
module skew_lane #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  if (Depth == 0) begin : g_bypass
    assign data_o = valid_i ? data_i : '0;
  end else begin : g_delay
    logic [Width-1:0] data_q [Depth];
    logic [Depth-1:0] valid_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= '0;
        for (int k = 0; k < int'(Depth); k++) data_q[k] <= '0;
      end else begin
        valid_q[0] <= valid_i;
        data_q[0]  <= data_i;
        for (int k = 1; k < int'(Depth); k++) begin
          valid_q[k] <= valid_q[k-1];
          data_q[k]  <= data_q[k-1];
        end
      end
    end

    assign data_o = valid_q[Depth-1] ? data_q[Depth-1] : '0;
  end

endmodule

// File: rtl/systolic_feeder.sv
// Streams one K-column tile from the operand buffer into an NxN systolic array with diagonal skew.
// Define SYSTOLIC_FEEDER_PERF_CNT_EN to add the per-tile busy cycle counter.
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int unsigned N      = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  systolic_feeder_if.slave bus
);

  localparam int unsigned FlushLen  = flush_len(N);
  localparam int unsigned FlushCntW = (FlushLen > 1) ? $clog2(FlushLen) : 1;

  state_e                 state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   pe_clear_q;
  logic                   rd_en_q;
  logic [ADDR_W-1:0]      rd_addr_q;
  logic [ADDR_W-1:0]      k_len_q;
  logic [FlushCntW-1:0]   flush_cnt_q;
  logic                   rd_vld_q;

  // rd_addr_q doubles as the FEED column counter; outputs are set on entry to each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pe_clear_q  <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      k_len_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      done_q     <= 1'b0;
      pe_clear_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q    <= StClear;
            busy_q     <= 1'b1;
            pe_clear_q <= 1'b1;
            k_len_q    <= bus.k_len;
          end
        end
        StClear: begin
          if (k_len_q != '0) begin
            state_q   <= StFeed;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StFeed: begin
          if (rd_addr_q == k_len_q - ADDR_W'(1)) begin
            state_q     <= StFlush;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            flush_cnt_q <= '0;
          end else begin
            rd_addr_q <= rd_addr_q + ADDR_W'(1);
          end
        end
        StFlush: begin
          if (flush_cnt_q == FlushCntW'(FlushLen - 1)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + FlushCntW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Buffer returns data one cycle after the strobe; the valid bit follows it.
  always_ff @(posedge clk) begin
    if (reset) rd_vld_q <= 1'b0;
    else       rd_vld_q <= rd_en_q;
  end

  logic [DataWidth-1:0] a_word [N];
  logic [DataWidth-1:0] b_word [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane #(
      .Depth (i),
      .Width (DataWidth)
    ) u_skew_a (
      .clk     (clk),
      .reset   (reset),
      .valid_i (rd_vld_q),
      .data_i  (bus.rd_data_a[i*DataWidth +: DataWidth]),
      .data_o  (a_word[i])
    );

    skew_lane #(
      .Depth (i),
      .Width (DataWidth)
    ) u_skew_b (
      .clk     (clk),
      .reset   (reset),
      .valid_i (rd_vld_q),
      .data_i  (bus.rd_data_b[i*DataWidth +: DataWidth]),
      .data_o  (b_word[i])
    );
  end

  always_comb begin
    bus.a_out = '0;
    bus.b_out = '0;
    for (int i = 0; i < int'(N); i++) begin
      bus.a_out[i*DataWidth +: DataWidth] = a_word[i];
      bus.b_out[i*DataWidth +: DataWidth] = b_word[i];
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pe_clear = pe_clear_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.rd_addr  = rd_addr_q;

`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
  logic [31:0] cycle_count_q;

  always_ff @(posedge clk) begin
    if (reset)                              cycle_count_q <= '0;
    else if (state_q == StIdle && bus.start) cycle_count_q <= '0;
    else if (busy_q)                        cycle_count_q <= cycle_count_q + 32'd1;
  end

  assign bus.cycle_count = cycle_count_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: per-cycle comparison against a timing/data model
// derived from tile length, with a behavioural operand buffer answering reads one cycle late.
module tb_systolic_feeder;
  import systolic_feeder_pkg::*;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = DataWidth;
  localparam int FL = 2 * N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .ADDR_W(AW)) bus ();

  systolic_feeder #(.N(N), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem_a [256][N];
  logic [DW-1:0] mem_b [256][N];

  int n_assert = 0;
  int n_fail   = 0;
  bit pend_en  = 1'b0;
  int pend_addr = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the buffer model answers last cycle's read, junk otherwise.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (pend_en) begin
        bus.rd_data_a[i*DW +: DW] = mem_a[pend_addr][i];
        bus.rd_data_b[i*DW +: DW] = mem_b[pend_addr][i];
      end else begin
        bus.rd_data_a[i*DW +: DW] = DW'($urandom);
        bus.rd_data_b[i*DW +: DW] = DW'($urandom);
      end
    end
    pend_en   = bus.rd_en;
    pend_addr = int'(bus.rd_addr);
    #1;
  endtask

  // Column f leaves the buffer at FEED cycle f (r = 1+f) and reaches lane i at r = f+2+i.
  function automatic logic [N*DW-1:0] exp_lanes(input int r, input int k, input bit sel_b);
    logic [N*DW-1:0] v;
    int f;
    v = '0;
    for (int i = 0; i < N; i++) begin
      f = r - 2 - i;
      if (f >= 0 && f < k) v[i*DW +: DW] = sel_b ? mem_b[f][i] : mem_a[f][i];
    end
    return v;
  endfunction

  task automatic fill_random();
    for (int a = 0; a < 256; a++)
      for (int i = 0; i < N; i++) begin
        mem_a[a][i] = DW'($urandom);
        mem_b[a][i] = DW'($urandom);
      end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".busy"},     64'(bus.busy),     64'd0);
    check({tag, ".done"},     64'(bus.done),     64'd0);
    check({tag, ".pe_clear"}, 64'(bus.pe_clear), 64'd0);
    check({tag, ".rd_en"},    64'(bus.rd_en),    64'd0);
    check({tag, ".rd_addr"},  64'(bus.rd_addr),  64'd0);
    check({tag, ".a_out"},    64'(bus.a_out),    64'd0);
    check({tag, ".b_out"},    64'(bus.b_out),    64'd0);
  endtask

  // r = 0 is CLEAR; runs through one IDLE cycle after DONE.
  task automatic run_tile(input int k, input bit spurious);
    int rdone;
    bit feed;
    rdone = (k == 0) ? 1 : 1 + k + FL;
    bus.k_len = AW'(k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.k_len = AW'($urandom);
    for (int r = 0; r <= rdone + 1; r++) begin
      feed = (r >= 1 && r <= k);
      check($sformatf("k%0d.busy@%0d", k, r),     64'(bus.busy),     64'(r <= rdone));
      check($sformatf("k%0d.done@%0d", k, r),     64'(bus.done),     64'(r == rdone));
      check($sformatf("k%0d.pe_clear@%0d", k, r), 64'(bus.pe_clear), 64'(r == 0));
      check($sformatf("k%0d.rd_en@%0d", k, r),    64'(bus.rd_en),    64'(feed));
      check($sformatf("k%0d.rd_addr@%0d", k, r),  64'(bus.rd_addr),  feed ? 64'(r - 1) : 64'd0);
      check($sformatf("k%0d.a_out@%0d", k, r),    64'(bus.a_out),    64'(exp_lanes(r, k, 1'b0)));
      check($sformatf("k%0d.b_out@%0d", k, r),    64'(bus.b_out),    64'(exp_lanes(r, k, 1'b1)));
      if (r <= rdone) begin
        bus.start = spurious && (((r + 1 == 2) && k >= 2) || (r + 1 == rdone));
        tick();
        bus.start = 1'b0;
      end
    end
`ifdef SYSTOLIC_FEEDER_PERF_CNT_EN
    check($sformatf("k%0d.cycle_count", k), 64'(bus.cycle_count), 64'(rdone + 1));
`endif
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.k_len     = '0;
    bus.rd_data_a = '0;
    bus.rd_data_b = '0;
    fill_random();

    reset = 1'b1;
    tick();
    tick();
    check_idle("reset");
    reset = 1'b0;

    // Lane-tagged A operand: lane i at address f holds 16*i+f.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) mem_a[f][i] = DW'(16 * i + f);
    run_tile(3, 1'b0);

    fill_random();
    run_tile(int'($urandom_range(2, 7)), 1'b1);

    run_tile(0, 1'b1);

    // Reset during FEED cycle 2, then start in the very next cycle.
    fill_random();
    bus.k_len = AW'(5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check($sformatf("midreset.rd_addr"), 64'(bus.rd_addr), 64'd2);
    reset = 1'b1;
    tick();
    check_idle("midreset");
    reset = 1'b0;
    run_tile(2, 1'b0);

    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_tile(int'($urandom_range(1, 20)), 1'($urandom));
    end

    fill_random();
    run_tile(255, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
